// File: rtl/axi_slave_mem_responder_pkg.sv
// Shared types and address arithmetic for the AXI4 memory responder.
// Burst stepping lives here so the AW and AR generators share one definition.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Reserved bursts and WRAP with an unsupported length both answer SLVERR.
  function automatic logic bad_burst(input burst_e b, input logic [7:0] len);
    return (b == BURST_RSVD) || ((b == BURST_WRAP) && !wrap_len_ok(len));
  endfunction

  function automatic logic [63:0] next_addr(input logic [63:0] addr, input logic [7:0] len,
                                            input burst_e b, input int unsigned blog2);
    logic [63:0] step, wsize;
    step  = 64'd1 << blog2;
    wsize = ({56'd0, len} + 64'd1) << blog2;
    case (b)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = wrap_len_ok(len)
                            ? ((addr & ~(wsize - 64'd1)) | ((addr + step) & (wsize - 64'd1)))
                            : addr + step;
      default:    next_addr = addr;
    endcase
  endfunction

endpackage

// File: rtl/axi_slave_mem_responder_if.sv
// AXI4 bus bundle (no cache/prot/qos/region/user/size) for the memory responder.
interface axi_slave_mem_responder_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [7:0]          AWLEN;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;
  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [7:0]          ARLEN;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;
  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi_slave_mem_responder_addr_gen.sv
// Beat address generator: next burst address, word index and window check.
module axi_mem_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [7:0]                   len_i,
  input  burst_e                       burst_i,
  output logic [ADDR_W-1:0]            next_o,
  output logic [$clog2(MEM_WORDS)-1:0] word_o,
  output logic                         in_range_o
);
  localparam int unsigned BLOG2  = $clog2(DATA_W / 8);
  localparam int          WIDX_W = $clog2(MEM_WORDS);

  assign next_o     = ADDR_W'(next_addr(64'(addr_i), len_i, burst_i, BLOG2));
  assign word_o     = addr_i[BLOG2 +: WIDX_W];
  // Wide compare so addresses past the window never alias into it.
  assign in_range_o = (64'(addr_i) >> BLOG2) < 64'(MEM_WORDS);
endmodule

// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave memory endpoint: independent write (AW/W/B) and read (AR/R) FSMs
// over a byte-strobed word memory, with DECERR/SLVERR reporting.
module axi_slave_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 1024
) (
  input logic                      ACLK,
  input logic                      ARESET,
  axi_slave_mem_responder_if.slave s
);
  localparam int STRB_W = DATA_W / 8;
  localparam int WIDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  // ---------------- write path ----------------
  wr_state_e         wst_q, wst_d;
  logic [ID_W-1:0]   wid_q;
  logic [ADDR_W-1:0] waddr_q, waddr_nxt;
  logic [7:0]        wlen_q, wbeat_q;
  burst_e            wburst_q;
  logic              wslv_q, wdec_q;
  logic [WIDX_W-1:0] wword;
  logic              w_inr, aw_hs, w_hs, b_hs, w_last_beat, w_bad;
  resp_e             bresp;

  axi_mem_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_aw_gen (
    .addr_i(waddr_q), .len_i(wlen_q), .burst_i(wburst_q),
    .next_o(waddr_nxt), .word_o(wword), .in_range_o(w_inr)
  );

  assign s.AWREADY   = (wst_q == W_IDLE) & ~ARESET;
  assign s.WREADY    = (wst_q == W_DATA) & ~ARESET;
  assign s.BVALID    = (wst_q == W_RESP) & ~ARESET;
  assign aw_hs       = s.AWVALID & s.AWREADY;
  assign w_hs        = s.WVALID & s.WREADY;
  assign b_hs        = s.BVALID & s.BREADY;
  assign w_last_beat = (wbeat_q == wlen_q);
  assign w_bad       = bad_burst(wburst_q, wlen_q);

  always_comb begin
    bresp = RESP_OKAY;
    if (wdec_q)      bresp = RESP_DECERR;
    else if (wslv_q) bresp = RESP_SLVERR;
  end

  assign s.BID   = {ID_W{s.BVALID}} & wid_q;
  assign s.BRESP = {2{s.BVALID}} & bresp;

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_IDLE:  if (aw_hs) wst_d = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) wst_d = W_RESP;
      W_RESP:  if (b_hs) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wst_q    <= W_IDLE;
      wid_q    <= '0;
      waddr_q  <= '0;
      wlen_q   <= '0;
      wbeat_q  <= '0;
      wburst_q <= BURST_INCR;
      wslv_q   <= 1'b0;
      wdec_q   <= 1'b0;
    end else begin
      wst_q <= wst_d;
      if (aw_hs) begin
        wid_q    <= s.AWID;
        waddr_q  <= s.AWADDR;
        wlen_q   <= s.AWLEN;
        wburst_q <= burst_e'(s.AWBURST);
        wbeat_q  <= '0;
        wslv_q   <= 1'b0;
        wdec_q   <= 1'b0;
      end
      // The burst always ends on the beat count; a misplaced WLAST only flags it.
      if (w_hs) begin
        waddr_q <= waddr_nxt;
        wbeat_q <= wbeat_q + 8'd1;
        if ((s.WLAST != w_last_beat) || w_bad) wslv_q <= 1'b1;
        if (!w_inr)                            wdec_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (w_hs && w_inr && (wburst_q != BURST_RSVD))
      for (int b = 0; b < STRB_W; b++)
        if (s.WSTRB[b]) mem_q[wword][b*8 +: 8] <= s.WDATA[b*8 +: 8];
  end

  // ---------------- read path ----------------
  // rptr_q holds the address of the next beat to fetch; the presented beat is
  // already registered in rdata_q/rresp_q/rlast_q so it stays stable under stall.
  rd_state_e         rdst_q, rdst_d;
  logic [ID_W-1:0]   rid_q;
  logic [ADDR_W-1:0] rptr_q, f_addr, f_next;
  logic [7:0]        rlen_q, rbeat_q, f_len;
  burst_e            rburst_q, f_burst;
  logic              rslv_q, rlast_q, f_slv, f_inr, ar_hs, r_hs, r_more, fetch, rv;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WIDX_W-1:0] f_word;
  resp_e             f_resp;

  assign s.ARREADY = (rdst_q == R_IDLE) & ~ARESET;
  assign rv        = (rdst_q == R_DATA) & ~ARESET;
  assign ar_hs     = s.ARVALID & s.ARREADY;
  assign r_hs      = rv & s.RREADY;
  assign r_more    = r_hs & ~rlast_q;
  assign fetch     = ar_hs | r_more;

  assign f_addr  = ar_hs ? s.ARADDR : rptr_q;
  assign f_len   = ar_hs ? s.ARLEN : rlen_q;
  assign f_burst = ar_hs ? burst_e'(s.ARBURST) : rburst_q;
  assign f_slv   = ar_hs ? bad_burst(burst_e'(s.ARBURST), s.ARLEN) : rslv_q;

  axi_mem_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) u_ar_gen (
    .addr_i(f_addr), .len_i(f_len), .burst_i(f_burst),
    .next_o(f_next), .word_o(f_word), .in_range_o(f_inr)
  );

  always_comb begin
    f_resp = RESP_OKAY;
    if (!f_inr)     f_resp = RESP_DECERR;
    else if (f_slv) f_resp = RESP_SLVERR;
  end

  always_comb begin
    rdst_d = rdst_q;
    case (rdst_q)
      R_IDLE:  if (ar_hs) rdst_d = R_DATA;
      R_DATA:  if (r_hs && rlast_q) rdst_d = R_IDLE;
      default: rdst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdst_q   <= R_IDLE;
      rid_q    <= '0;
      rptr_q   <= '0;
      rlen_q   <= '0;
      rbeat_q  <= '0;
      rburst_q <= BURST_INCR;
      rslv_q   <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= '0;
    end else begin
      rdst_q <= rdst_d;
      if (ar_hs) begin
        rid_q    <= s.ARID;
        rlen_q   <= s.ARLEN;
        rburst_q <= burst_e'(s.ARBURST);
        rslv_q   <= f_slv;
        rbeat_q  <= '0;
        rlast_q  <= (s.ARLEN == 8'd0);
      end else if (r_more) begin
        rbeat_q <= rbeat_q + 8'd1;
        rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
      end
      if (fetch) begin
        rptr_q  <= f_next;
        rresp_q <= f_resp;
      end
    end
  end

  // Separate from the write block so a same-cycle read sees the old word.
  always_ff @(posedge ACLK) begin
    if (fetch) rdata_q <= (f_inr && (f_burst != BURST_RSVD)) ? mem_q[f_word] : '0;
  end

  assign s.RVALID = rv;
  assign s.RID    = {ID_W{rv}} & rid_q;
  assign s.RDATA  = {DATA_W{rv}} & rdata_q;
  assign s.RRESP  = {2{rv}} & rresp_q;
  assign s.RLAST  = rv & rlast_q;
endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Scenario bench for axi_slave_mem_responder with queued expected responses.
module tb_axi_slave_mem_responder;
  localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32, MEM_WORDS = 1024;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;
  always #5 ACLK = ~ACLK;

  axi_slave_mem_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  axi_slave_mem_responder #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS))
    dut (.ACLK(ACLK), .ARESET(ARESET), .s(bus));

  typedef struct packed {logic [31:0] data; logic [1:0] resp; logic last; logic [3:0] id;} rexp_t;
  typedef struct packed {logic [1:0] resp; logic [3:0] id;} bexp_t;

  rexp_t       rq[$];
  rexp_t       rgot[$];
  bexp_t       bq[$];
  logic [31:0] wd [16];
  int          checks = 0;
  int          passes = 0;

  task automatic drive_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bt, output bit to);
    int n = 0;
    bus.AWID = id; bus.AWADDR = a; bus.AWLEN = len; bus.AWBURST = bt; bus.AWVALID = 1'b1;
    while (!bus.AWREADY && n < 100) begin @(posedge ACLK); #1; n++; end
    to = !bus.AWREADY;
    if (!to) begin @(posedge ACLK); #1; end
    bus.AWVALID = 1'b0;
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bt, output bit to);
    int n = 0;
    bus.ARID = id; bus.ARADDR = a; bus.ARLEN = len; bus.ARBURST = bt; bus.ARVALID = 1'b1;
    while (!bus.ARREADY && n < 100) begin @(posedge ACLK); #1; n++; end
    to = !bus.ARREADY;
    if (!to) begin @(posedge ACLK); #1; end
    bus.ARVALID = 1'b0;
  endtask

  task automatic drive_w(input logic [7:0] len, input logic [3:0] strb, input int wlast_at,
                         output int acc, output bit to);
    int n;
    acc = 0; to = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      bus.WDATA = wd[i]; bus.WSTRB = strb; bus.WLAST = (i == wlast_at); bus.WVALID = 1'b1;
      while (!bus.WREADY && n < 100) begin @(posedge ACLK); #1; n++; end
      if (!bus.WREADY) begin to = 1'b1; break; end
      @(posedge ACLK); #1;
      acc++;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [1:0] bt, input logic [3:0] strb, input int wlast_at,
                             output int acc, output bexp_t got, output bit to);
    int n = 0;
    acc = 0; got = '0;
    drive_aw(id, a, len, bt, to);
    if (to) return;
    drive_w(len, strb, wlast_at, acc, to);
    if (to) return;
    while (!bus.BVALID && n < 100) begin @(posedge ACLK); #1; n++; end
    if (!bus.BVALID) begin to = 1'b1; return; end
    got = '{bus.BRESP, bus.BID};
    @(posedge ACLK); #1;
  endtask

  task automatic get_r(output rexp_t g, output bit to);
    int n = 0;
    g = '0;
    while (!bus.RVALID && n < 100) begin @(posedge ACLK); #1; n++; end
    to = !bus.RVALID;
    if (to) return;
    g = '{bus.RDATA, bus.RRESP, bus.RLAST, bus.RID};
    @(posedge ACLK); #1;
  endtask

  task automatic collect_r(input logic [7:0] len, output bit to);
    rexp_t g;
    to = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      get_r(g, to);
      if (to) break;
      rgot.push_back(g);
    end
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [1:0] bt, output bit to);
    rgot.delete();
    drive_ar(id, a, len, bt, to);
    if (!to) collect_r(len, to);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    checks++;
    if ({bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.AWREADY, bus.ARREADY, bus.WREADY, bus.BVALID, bus.RVALID});
    else passes++;
    checks++;
    if ({bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST} !== '0)
      $display("FAIL reset_data: got %h want 0",
               {bus.BID, bus.BRESP, bus.RID, bus.RDATA, bus.RRESP, bus.RLAST});
    else passes++;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if ({bus.AWREADY, bus.ARREADY} !== 2'b11)
      $display("FAIL reset_ready: got %b want 11", {bus.AWREADY, bus.ARREADY});
    else passes++;
  endtask

  task automatic test_incr();
    bexp_t gb, eb; rexp_t g, e; bit to; int acc;
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    bq.push_back('{2'd0, 4'd5});
    write_burst(4'd5, 32'h10, 8'd3, 2'b01, 4'hF, 3, acc, gb, to);
    eb = bq.pop_front(); checks++;
    if (to || gb !== eb) $display("FAIL incr_b: got %h to=%0b want %h", gb, to, eb); else passes++;
    for (int i = 0; i < 4; i++) rq.push_back('{32'hA0 + 32'(i), 2'd0, (i == 3), 4'd3});
    rgot.delete();
    drive_ar(4'd3, 32'h10, 8'd3, 2'b01, to);
    checks++;
    if (to || bus.RVALID !== 1'b1) $display("FAIL incr_rvalid_lat: got %b want 1", bus.RVALID);
    else passes++;
    collect_r(8'd3, to);
    for (int k = 0; rq.size() > 0; k++) begin
      e = rq.pop_front(); g = '0;
      if (k < rgot.size()) g = rgot[k];
      checks++;
      if (to || g !== e) $display("FAIL incr_r%0d: got %h want %h", k, g, e); else passes++;
    end
  endtask

  task automatic test_wrap();
    bexp_t gb, eb; rexp_t g, e; bit to; int acc;
    for (int i = 0; i < 4; i++) wd[i] = 32'hC0DE0030 + 32'(4 * i);
    bq.push_back('{2'd0, 4'd1});
    write_burst(4'd1, 32'h30, 8'd3, 2'b01, 4'hF, 3, acc, gb, to);
    eb = bq.pop_front(); checks++;
    if (to || gb !== eb) $display("FAIL wrap_b: got %h want %h", gb, eb); else passes++;
    rq.push_back('{32'hC0DE0038, 2'd0, 1'b0, 4'd2});
    rq.push_back('{32'hC0DE003C, 2'd0, 1'b0, 4'd2});
    rq.push_back('{32'hC0DE0030, 2'd0, 1'b0, 4'd2});
    rq.push_back('{32'hC0DE0034, 2'd0, 1'b1, 4'd2});
    read_burst(4'd2, 32'h38, 8'd3, 2'b10, to);
    for (int k = 0; rq.size() > 0; k++) begin
      e = rq.pop_front(); g = '0;
      if (k < rgot.size()) g = rgot[k];
      checks++;
      if (to || g !== e) $display("FAIL wrap_r%0d: got %h want %h", k, g, e); else passes++;
    end
  endtask

  task automatic test_out_of_range();
    bexp_t gb, eb; rexp_t g, e; bit to; int acc;
    wd[0] = 32'hDEADBEEF;
    bq.push_back('{2'd0, 4'd6});
    write_burst(4'd6, 32'h0, 8'd0, 2'b01, 4'hF, 0, acc, gb, to);
    wd[0] = 32'h11111111; wd[1] = 32'h22222222;
    bq.push_back('{2'd3, 4'd7});
    write_burst(4'd7, 32'hFFC, 8'd1, 2'b01, 4'hF, 1, acc, gb, to);
    eb = bq.pop_front(); eb = bq.pop_front(); checks++;
    if (to || gb !== eb) $display("FAIL oor_b: got %h want %h", gb, eb); else passes++;
    rq.push_back('{32'h11111111, 2'd0, 1'b0, 4'd8});
    rq.push_back('{32'h00000000, 2'd3, 1'b1, 4'd8});
    read_burst(4'd8, 32'hFFC, 8'd1, 2'b01, to);
    for (int k = 0; rq.size() > 0; k++) begin
      e = rq.pop_front(); g = '0;
      if (k < rgot.size()) g = rgot[k];
      checks++;
      if (to || g !== e) $display("FAIL oor_r%0d: got %h want %h", k, g, e); else passes++;
    end
    // word 0 must not be clobbered by the dropped 0x1000 beat
    rq.push_back('{32'hDEADBEEF, 2'd0, 1'b1, 4'd8});
    read_burst(4'd8, 32'h0, 8'd0, 2'b01, to);
    e = rq.pop_front(); g = '0;
    if (rgot.size() > 0) g = rgot[0];
    checks++;
    if (to || g !== e) $display("FAIL oor_alias: got %h want %h", g, e); else passes++;
  endtask

  task automatic test_early_wlast();
    bexp_t gb, eb; rexp_t g, e; bit to; int acc;
    for (int i = 0; i < 4; i++) wd[i] = 32'h5000 + 32'(i);
    bq.push_back('{2'd2, 4'd9});
    write_burst(4'd9, 32'h40, 8'd3, 2'b01, 4'hF, 1, acc, gb, to);
    eb = bq.pop_front(); checks++;
    if (to || gb !== eb) $display("FAIL wlast_b: got %h want %h", gb, eb); else passes++;
    checks++;
    if (acc !== 4) $display("FAIL wlast_beats: got %0d want 4", acc); else passes++;
    for (int i = 0; i < 4; i++) rq.push_back('{32'h5000 + 32'(i), 2'd0, (i == 3), 4'd4});
    read_burst(4'd4, 32'h40, 8'd3, 2'b01, to);
    for (int k = 0; rq.size() > 0; k++) begin
      e = rq.pop_front(); g = '0;
      if (k < rgot.size()) g = rgot[k];
      checks++;
      if (to || g !== e) $display("FAIL wlast_r%0d: got %h want %h", k, g, e); else passes++;
    end
  endtask

  task automatic test_fixed_strobe();
    bexp_t gb, eb; rexp_t g, e; bit to; int acc;
    wd[0] = 32'h12345678;
    bq.push_back('{2'd0, 4'd1});
    write_burst(4'd1, 32'h10, 8'd0, 2'b01, 4'h6, 0, acc, gb, to);
    eb = bq.pop_front(); checks++;
    if (to || gb !== eb) $display("FAIL strb_b: got %h want %h", gb, eb); else passes++;
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    bq.push_back('{2'd0, 4'd2});
    write_burst(4'd2, 32'h80, 8'd2, 2'b00, 4'hF, 2, acc, gb, to);
    eb = bq.pop_front(); checks++;
    if (to || gb !== eb) $display("FAIL fixed_b: got %h want %h", gb, eb); else passes++;
    wd[0] = 32'hFFFFFFFF;
    bq.push_back('{2'd2, 4'd3});
    write_burst(4'd3, 32'h14, 8'd0, 2'b11, 4'hF, 0, acc, gb, to);
    eb = bq.pop_front(); checks++;
    if (to || gb !== eb) $display("FAIL rsvd_b: got %h want %h", gb, eb); else passes++;
    // partial strobe, FIXED beats, reserved read, unchanged word, WRAP with len 2
    rq.push_back('{32'h003456A0, 2'd0, 1'b1, 4'd5});
    rq.push_back('{32'h00000003, 2'd0, 1'b0, 4'd5});
    rq.push_back('{32'h00000003, 2'd0, 1'b1, 4'd5});
    rq.push_back('{32'h00000000, 2'd2, 1'b0, 4'd5});
    rq.push_back('{32'h00000000, 2'd2, 1'b1, 4'd5});
    rq.push_back('{32'h000000A1, 2'd0, 1'b1, 4'd5});
    rq.push_back('{32'hC0DE0030, 2'd2, 1'b0, 4'd5});
    rq.push_back('{32'hC0DE0034, 2'd2, 1'b0, 4'd5});
    rq.push_back('{32'hC0DE0038, 2'd2, 1'b1, 4'd5});
    read_burst(4'd5, 32'h10, 8'd0, 2'b01, to);
    for (int k = 0; k < 1; k++) begin
      e = rq.pop_front(); g = '0; if (k < rgot.size()) g = rgot[k];
      checks++; if (to || g !== e) $display("FAIL strb_r: got %h want %h", g, e); else passes++;
    end
    read_burst(4'd5, 32'h80, 8'd1, 2'b00, to);
    for (int k = 0; k < 2; k++) begin
      e = rq.pop_front(); g = '0; if (k < rgot.size()) g = rgot[k];
      checks++; if (to || g !== e) $display("FAIL fixed_r%0d: got %h want %h", k, g, e); else passes++;
    end
    read_burst(4'd5, 32'h10, 8'd1, 2'b11, to);
    for (int k = 0; k < 2; k++) begin
      e = rq.pop_front(); g = '0; if (k < rgot.size()) g = rgot[k];
      checks++; if (to || g !== e) $display("FAIL rsvd_r%0d: got %h want %h", k, g, e); else passes++;
    end
    read_burst(4'd5, 32'h14, 8'd0, 2'b01, to);
    for (int k = 0; k < 1; k++) begin
      e = rq.pop_front(); g = '0; if (k < rgot.size()) g = rgot[k];
      checks++; if (to || g !== e) $display("FAIL rsvd_nowrite: got %h want %h", g, e); else passes++;
    end
    read_burst(4'd5, 32'h30, 8'd2, 2'b10, to);
    for (int k = 0; k < 3; k++) begin
      e = rq.pop_front(); g = '0; if (k < rgot.size()) g = rgot[k];
      checks++; if (to || g !== e) $display("FAIL badwrap_r%0d: got %h want %h", k, g, e); else passes++;
    end
  endtask

  task automatic test_backpressure_reset();
    rexp_t g, e; bit to;
    rq.push_back('{32'hC0DE0030, 2'd0, 1'b0, 4'd6});
    rq.push_back('{32'hC0DE0034, 2'd0, 1'b0, 4'd6});
    drive_ar(4'd6, 32'h30, 8'd3, 2'b01, to);
    get_r(g, to);
    e = rq.pop_front(); checks++;
    if (to || g !== e) $display("FAIL bp_r0: got %h want %h", g, e); else passes++;
    bus.RREADY = 1'b0;
    e = rq.pop_front();
    for (int c = 0; c < 5; c++) begin
      @(posedge ACLK); #1;
      checks++;
      if ({bus.RDATA, bus.RRESP, bus.RLAST, bus.RID} !== e || bus.RVALID !== 1'b1)
        $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", c, bus.RVALID,
                 {bus.RDATA, bus.RRESP, bus.RLAST, bus.RID}, e);
      else passes++;
    end
    ARESET = 1'b1;
    rq.delete();
    @(posedge ACLK); #1;
    checks++;
    if (bus.RVALID !== 1'b0) $display("FAIL bp_rst_rvalid: got %b want 0", bus.RVALID); else passes++;
    ARESET = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if (bus.ARREADY !== 1'b1) $display("FAIL bp_rst_arready: got %b want 1", bus.ARREADY); else passes++;
    bus.RREADY = 1'b1;
  endtask

  initial begin
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b1;
    test_reset();
    test_incr();
    test_wrap();
    test_out_of_range();
    test_early_wlast();
    test_fixed_strobe();
    test_backpressure_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
